mips_mem_if: RTL and testbench
==============================

// Module: mips_mem_if
// PURPOSE
//  Memory interface unit between the pipelined MIPS core and variable-latency instruction/data RAMs.
//  Replaces the fixed single-cycle ena/wea wiring with req/ack handshakes on both memory ports.
//  Produces a single pipeline stall so that fetch and data access both complete before the core advances.
//  Flags timeouts and misaligned accesses through a sticky error output.
// PARAMETERS
//  AW       32  address width (byte address; bits [1:0] must be 0 for word access)
//  DW       32  data width
//  TIMEOUT  16  max cycles a req may wait for ack before forced completion (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-low
//  core_pc      in   AW  fetch address from core (held stable while stall=1)
//  core_inst    out  DW  fetched instruction to core decode
//  core_den     in   1   core requests a data access this step
//  core_dwe     in   1   data write (1) / read (0), valid with core_den
//  core_daddr   in   AW  data address (alu result of MEM stage)
//  core_dwdata  in   DW  data write value
//  core_drdata  out  DW  data read value to core
//  stall        out  1   1 = core must hold all pipeline registers and pc
//  err          out  1   sticky error: timeout or misaligned access
//  imem_req     out  1   instruction request
//  imem_addr    out  AW  instruction address (= core_pc)
//  imem_ack     in   1   instruction data valid this cycle
//  imem_rdata   in   DW  instruction data
//  dmem_req     out  1   data request
//  dmem_we      out  1   data write enable (= core_dwe while dmem_req)
//  dmem_addr    out  AW  data address (= core_daddr)
//  dmem_wdata   out  DW  data write value (= core_dwdata)
//  dmem_ack     in   1   data access complete this cycle (read data valid if read)
//  dmem_rdata   in   DW  data read value
// BEHAVIOUR
//  Reset (rst=0): I-FSM and D-FSM = IDLE; core_inst=0, core_drdata=0, err=0, stall=1, imem_req=0, dmem_req=0, timers=0.
//  I-FSM: IDLE -> REQ unconditionally on first clock after reset release.
//   REQ: imem_req=1. On imem_ack: capture imem_rdata into inst_buf and go to DONE (or back to REQ if advance same cycle).
//   REQ: if timer reaches TIMEOUT-1 without ack, set err, load inst_buf=0 and go to DONE.
//   DONE: imem_req=0; hold until advance, then go to REQ.
//  D-FSM: identical structure on the dmem port. REQ entered only while core_den=1; otherwise stays IDLE (not needed).
//   A write completes on dmem_ack with no data capture; a read captures dmem_rdata into drd_buf.
//  i_ok = (I in DONE) | (I in REQ & imem_ack).
//  d_ok = ~core_den | (D in DONE) | (D in REQ & dmem_ack).
//  advance = i_ok & d_ok & (I not IDLE); stall = ~advance (combinational).
//  On advance both FSMs return to REQ/IDLE; the core changes core_pc/core_den on the same edge.
//  core_inst = (I in REQ & imem_ack) ? imem_rdata : inst_buf; core_drdata uses the same rule with dmem_ack and drd_buf.
//  Zero-wait memory (ack in same cycle as req): stall=0 every cycle, one instruction per clock, no added latency.
//  N-cycle ack latency: stall=1 for N cycles; the request stays asserted with constant addr/wdata throughout.
//  Misaligned access (addr[1:0]!=0): no req is issued on that port. Set err and complete on the next cycle with data 0.
//   A misaligned write never reaches dmem.
//  Timer: per-port counter cleared on entering REQ, increments each REQ cycle without ack; width clog2(TIMEOUT)+1.
//  Ack in the same cycle the timer expires: the ack wins; no error is raised.
//  Ack while not in REQ: ignored; no state change.
//  err is sticky until reset; it never blocks further operation.
//  Reset mid-request: req drops immediately (async). A late ack after reset release is ignored.
// TESTING
//  Zero-wait: imem_ack=1 tied, 8 sequential pcs 0x0..0x1C -> stall=0 all cycles; core_inst follows imem_rdata with 0 latency.
//  I-latency 3: ack on 3rd cycle with rdata 0x2002_0005 -> stall=1 for 2 cycles; core_inst=0x2002_0005 on the advance cycle.
//  Load with dmem_ack 2 cycles after imem_ack: stall holds until dmem_ack; core_drdata=0xDEAD_BEEF; inst_buf held meanwhile.
//  Store to 0x40, data 0x1234: dmem_req=1, dmem_we=1, addr 0x40, wdata 0x1234 stable until ack; exactly one accepted write.
//  Timeout: TIMEOUT=4, dmem_ack never asserted -> err=1 after 4 REQ cycles; core_drdata=0; stall drops; err stays 1.
//  Misaligned core_daddr=0x41 with store: dmem_req never asserted; err=1; advance next cycle. rst pulsed mid-REQ -> outputs return to reset values.

Source files
------------

// File: rtl/mips_mem_if_if.sv
// Request/acknowledge memory port shared by the instruction and data sides.
// The memory interface unit drives the master modport; the RAM drives the slave modport.
interface mips_mem_if_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output we, output addr, output wdata, input ack, input rdata);
  modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/mips_mem_if.sv
// Memory interface unit: req/ack handshakes to variable-latency instruction and data RAMs,
// a single pipeline stall until both accesses complete, and a sticky timeout/misalign error.
module mips_mem_if #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [AW-1:0]        i_core_pc,
  output logic [DW-1:0]        o_core_inst,
  input  logic                 i_core_den,
  input  logic                 i_core_dwe,
  input  logic [AW-1:0]        i_core_daddr,
  input  logic [DW-1:0]        i_core_dwdata,
  output logic [DW-1:0]        o_core_drdata,
  output logic                 o_stall,
  output logic                 o_err,
  mips_mem_if_if.master        imem,
  mips_mem_if_if.master        dmem
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMax = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e        r_i_state, w_i_state_nxt;
  state_e        r_d_state, w_d_state_nxt;
  logic [TW-1:0] r_i_timer, w_i_timer_nxt;
  logic [TW-1:0] r_d_timer, w_d_timer_nxt;
  logic [DW-1:0] r_inst_buf, w_inst_buf_nxt;
  logic [DW-1:0] r_drd_buf, w_drd_buf_nxt;
  logic          r_err, w_err_nxt;

  logic w_i_align, w_d_align;
  logic w_i_hit, w_d_hit;
  logic w_i_tmo, w_d_tmo;
  logic w_i_mis, w_d_mis;
  logic w_i_ok, w_d_ok, w_adv;

  assign w_i_align = (i_core_pc[1:0] == 2'b00);
  assign w_d_align = (i_core_daddr[1:0] == 2'b00);

  // Misaligned ports never raise req, so an ack there is not a completion.
  assign w_i_hit = (r_i_state == StReq) & w_i_align & imem.ack;
  assign w_d_hit = (r_d_state == StReq) & w_d_align & dmem.ack;
  assign w_i_tmo = (r_i_state == StReq) & w_i_align & ~imem.ack & (r_i_timer == TMax);
  assign w_d_tmo = (r_d_state == StReq) & w_d_align & ~dmem.ack & (r_d_timer == TMax);
  assign w_i_mis = (r_i_state == StReq) & ~w_i_align;
  assign w_d_mis = (r_d_state == StReq) & ~w_d_align;

  assign w_i_ok = (r_i_state == StDone) | w_i_hit;
  assign w_d_ok = ~i_core_den | (r_d_state == StDone) | w_d_hit;
  assign w_adv  = w_i_ok & w_d_ok & (r_i_state != StIdle);

  always_comb begin
    w_i_state_nxt  = r_i_state;
    w_i_timer_nxt  = r_i_timer;
    w_inst_buf_nxt = r_inst_buf;
    unique case (r_i_state)
      StIdle: begin
        w_i_state_nxt = StReq;
        w_i_timer_nxt = '0;
      end
      StReq: begin
        if (w_i_hit) begin
          w_inst_buf_nxt = imem.rdata;
          w_i_state_nxt  = w_adv ? StReq : StDone;
          w_i_timer_nxt  = '0;
        end else if (w_i_mis || w_i_tmo) begin
          w_inst_buf_nxt = '0;
          w_i_state_nxt  = StDone;
        end else begin
          w_i_timer_nxt = r_i_timer + TW'(1);
        end
      end
      StDone: begin
        if (w_adv) begin
          w_i_state_nxt = StReq;
          w_i_timer_nxt = '0;
        end
      end
      default: w_i_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_d_state_nxt = r_d_state;
    w_d_timer_nxt = r_d_timer;
    w_drd_buf_nxt = r_drd_buf;
    unique case (r_d_state)
      StIdle: begin
        if (i_core_den) begin
          w_d_state_nxt = StReq;
          w_d_timer_nxt = '0;
        end
      end
      StReq: begin
        if (w_d_hit) begin
          if (!i_core_dwe) w_drd_buf_nxt = dmem.rdata;
          w_d_state_nxt = w_adv ? StIdle : StDone;
        end else if (w_adv) begin
          // Core withdrew the data request; nothing left to wait for.
          w_d_state_nxt = StIdle;
        end else if (w_d_mis || w_d_tmo) begin
          w_drd_buf_nxt = '0;
          w_d_state_nxt = StDone;
        end else begin
          w_d_timer_nxt = r_d_timer + TW'(1);
        end
      end
      StDone: begin
        if (w_adv) w_d_state_nxt = StIdle;
      end
      default: w_d_state_nxt = StIdle;
    endcase
  end

  assign w_err_nxt = r_err | w_i_mis | w_i_tmo | w_d_mis | w_d_tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i_state  <= StIdle;
      r_d_state  <= StIdle;
      r_i_timer  <= '0;
      r_d_timer  <= '0;
      r_inst_buf <= '0;
      r_drd_buf  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_i_state  <= w_i_state_nxt;
      r_d_state  <= w_d_state_nxt;
      r_i_timer  <= w_i_timer_nxt;
      r_d_timer  <= w_d_timer_nxt;
      r_inst_buf <= w_inst_buf_nxt;
      r_drd_buf  <= w_drd_buf_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign imem.req   = (r_i_state == StReq) & w_i_align;
  assign imem.we    = 1'b0;
  assign imem.addr  = i_core_pc;
  assign imem.wdata = '0;

  assign dmem.req   = (r_d_state == StReq) & w_d_align;
  assign dmem.we    = dmem.req & i_core_dwe;
  assign dmem.addr  = i_core_daddr;
  assign dmem.wdata = i_core_dwdata;

  // Bypass on the ack cycle gives zero added latency for single-cycle RAMs.
  assign o_core_inst   = w_i_hit ? imem.rdata : r_inst_buf;
  assign o_core_drdata = (w_d_hit && !i_core_dwe) ? dmem.rdata : r_drd_buf;
  assign o_stall       = ~w_adv;
  assign o_err         = r_err;

endmodule

// File: tb/tb_mips_mem_if.sv
// Scenario bench for mips_mem_if: expected fetch/load data is queued when the RAM side
// returns it and popped when the core is allowed to advance.
module tb_mips_mem_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] core_pc, core_daddr;
  logic [DW-1:0] core_inst, core_dwdata, core_drdata;
  logic          core_den, core_dwe, stall, err;

  mips_mem_if_if #(.AW(AW), .DW(DW)) imem_bus ();
  mips_mem_if_if #(.AW(AW), .DW(DW)) dmem_bus ();

  mips_mem_if #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_core_pc     (core_pc),
    .o_core_inst   (core_inst),
    .i_core_den    (core_den),
    .i_core_dwe    (core_dwe),
    .i_core_daddr  (core_daddr),
    .i_core_dwdata (core_dwdata),
    .o_core_drdata (core_drdata),
    .o_stall       (stall),
    .o_err         (err),
    .imem          (imem_bus.master),
    .dmem          (dmem_bus.master)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  logic [31:0]   exp_iq[$];
  logic [31:0]   exp_dq[$];
  logic [31:0]   exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    core_pc = '0; core_den = 1'b0; core_dwe = 1'b0; core_daddr = '0; core_dwdata = '0;
    imem_bus.ack = 1'b0; imem_bus.rdata = '0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %0h want 1", stall); end
    n_vec++; if (core_inst !== '0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", core_inst); end
    n_vec++; if (core_drdata !== '0) begin n_bad++; $display("FAIL rst_drdata: got %h want 0", core_drdata); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0h want 0", err); end
    n_vec++; if (imem_bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_ireq: got %0h want 0", imem_bus.req); end
    n_vec++; if (dmem_bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_dreq: got %0h want 0", dmem_bus.req); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    imem_bus.ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      core_pc = 32'(i * 4);
      imem_bus.rdata = 32'h2000_0000 + 32'(i * 32'h0001_0003);
      exp_iq.push_back(imem_bus.rdata);
      @(negedge clk);
      n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zw_stall[%0d]: got %0h want 0", i, stall); end
      n_vec++; if (imem_bus.addr !== core_pc) begin n_bad++; $display("FAIL zw_addr[%0d]: got %h want %h", i, imem_bus.addr, core_pc); end
      exp = exp_iq.pop_front();
      n_vec++; if (core_inst !== exp) begin n_bad++; $display("FAIL zw_inst[%0d]: got %h want %h", i, core_inst, exp); end
      step();
    end
    imem_bus.ack = 1'b0;
  endtask

  task automatic test_i_latency();
    core_pc = 32'h20;
    for (int k = 0; k < 3; k++) begin
      imem_bus.ack = (k == 2);
      imem_bus.rdata = (k == 2) ? 32'h2002_0005 : 32'hFFFF_FFFF;
      if (k == 2) exp_iq.push_back(32'h2002_0005);
      @(negedge clk);
      n_vec++; if (imem_bus.req !== 1'b1) begin n_bad++; $display("FAIL lat_req[%0d]: got %0h want 1", k, imem_bus.req); end
      n_vec++; if (stall !== (k != 2)) begin n_bad++; $display("FAIL lat_stall[%0d]: got %0h want %0h", k, stall, (k != 2)); end
      if (k == 2) begin
        n_vec++;
        if (exp_iq.size() == 0) begin n_bad++; $display("FAIL lat_inst: got %h want <empty queue>", core_inst); end
        else begin
          exp = exp_iq.pop_front();
          if (core_inst !== exp) begin n_bad++; $display("FAIL lat_inst: got %h want %h", core_inst, exp); end
        end
      end
      step();
    end
    imem_bus.ack = 1'b0;
  endtask

  task automatic test_load();
    core_pc = 32'h24; core_den = 1'b1; core_dwe = 1'b0; core_daddr = 32'h80;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h8C41_0000;
    exp_iq.push_back(32'h8C41_0000);
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ld_stall_a: got %0h want 1", stall); end
    step();
    imem_bus.ack = 1'b0; imem_bus.rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ld_stall_b: got %0h want 1", stall); end
    n_vec++; if (dmem_bus.req !== 1'b1 || dmem_bus.we !== 1'b0) begin n_bad++; $display("FAIL ld_req: got req=%0h we=%0h want req=1 we=0", dmem_bus.req, dmem_bus.we); end
    n_vec++; if (core_inst !== 32'h8C41_0000) begin n_bad++; $display("FAIL ld_inst_hold: got %h want 8c410000", core_inst); end
    step();
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hDEAD_BEEF;
    exp_dq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_stall_c: got %0h want 0", stall); end
    exp = exp_iq.pop_front();
    n_vec++; if (core_inst !== exp) begin n_bad++; $display("FAIL ld_inst: got %h want %h", core_inst, exp); end
    exp = exp_dq.pop_front();
    n_vec++; if (core_drdata !== exp) begin n_bad++; $display("FAIL ld_data: got %h want %h", core_drdata, exp); end
    step();
    core_den = 1'b0; dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    core_pc = 32'h28; imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_0020;
    exp_iq.push_back(32'h0000_0020);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_next_stall: got %0h want 0", stall); end
    n_vec++; if (core_drdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ld_data_hold: got %h want deadbeef", core_drdata); end
    exp = exp_iq.pop_front();
    n_vec++; if (core_inst !== exp) begin n_bad++; $display("FAIL ld_next_inst: got %h want %h", core_inst, exp); end
    step();
    imem_bus.ack = 1'b0;
  endtask

  task automatic test_store();
    int writes = 0;
    core_pc = 32'h2C; core_den = 1'b1; core_dwe = 1'b1; core_daddr = 32'h40; core_dwdata = 32'h1234;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'hAC02_0040;
    exp_iq.push_back(32'hAC02_0040);
    @(negedge clk);
    if (dmem_bus.req && dmem_bus.ack) writes++;
    n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL st_stall_a: got %0h want 1", stall); end
    step();
    imem_bus.ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dmem_bus.ack = (k == 2);
      @(negedge clk);
      if (dmem_bus.req && dmem_bus.we && dmem_bus.ack) writes++;
      n_vec++;
      if (dmem_bus.req !== 1'b1 || dmem_bus.we !== 1'b1 || dmem_bus.addr !== 32'h40 || dmem_bus.wdata !== 32'h1234) begin
        n_bad++;
        $display("FAIL st_bus[%0d]: got req=%0h we=%0h addr=%h wdata=%h want 1 1 00000040 00001234",
                 k, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata);
      end
      n_vec++; if (stall !== (k != 2)) begin n_bad++; $display("FAIL st_stall[%0d]: got %0h want %0h", k, stall, (k != 2)); end
      if (k == 2) begin
        exp = exp_iq.pop_front();
        n_vec++; if (core_inst !== exp) begin n_bad++; $display("FAIL st_inst: got %h want %h", core_inst, exp); end
      end
      step();
    end
    core_den = 1'b0; core_dwe = 1'b0; dmem_bus.ack = 1'b0;
    n_vec++; if (writes != 1) begin n_bad++; $display("FAIL st_count: got %0d want 1", writes); end
  endtask

  task automatic test_timeout();
    core_pc = 32'h30; core_den = 1'b1; core_dwe = 1'b0; core_daddr = 32'h84;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h8C43_0004;
    dmem_bus.rdata = 32'h5A5A_5A5A;
    exp_iq.push_back(32'h8C43_0004);
    @(negedge clk);
    step();
    imem_bus.ack = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      n_vec++; if (stall !== 1'b1 || err !== 1'b0 || dmem_bus.req !== 1'b1) begin
        n_bad++; $display("FAIL to_wait[%0d]: got stall=%0h err=%0h req=%0h want 1 0 1", k, stall, err, dmem_bus.req);
      end
      step();
    end
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %0h want 1", err); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL to_stall: got %0h want 0", stall); end
    n_vec++; if (core_drdata !== '0) begin n_bad++; $display("FAIL to_data: got %h want 0", core_drdata); end
    exp = exp_iq.pop_front();
    n_vec++; if (core_inst !== exp) begin n_bad++; $display("FAIL to_inst: got %h want %h", core_inst, exp); end
    step();
    core_den = 1'b0;
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %0h want 1", err); end
  endtask

  // Entered at a falling edge with the fetch port in REQ.
  task automatic test_reset_mid();
    core_pc = 32'h34;
    n_vec++; if (imem_bus.req !== 1'b1) begin n_bad++; $display("FAIL rm_req_pre: got %0h want 1", imem_bus.req); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (imem_bus.req !== 1'b0 || dmem_bus.req !== 1'b0) begin n_bad++; $display("FAIL rm_req: got i=%0h d=%0h want 0 0", imem_bus.req, dmem_bus.req); end
    n_vec++; if (stall !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL rm_out: got stall=%0h err=%0h want 1 0", stall, err); end
    n_vec++; if (core_inst !== '0 || core_drdata !== '0) begin n_bad++; $display("FAIL rm_data: got %h %h want 0 0", core_inst, core_drdata); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'hBAD0_0BAD;
    #1;
    n_vec++; if (stall !== 1'b1 || core_inst !== '0) begin n_bad++; $display("FAIL rm_late_ack: got stall=%0h inst=%h want 1 0", stall, core_inst); end
    step();
    imem_bus.ack = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_bus.req !== 1'b1 || core_inst !== '0) begin n_bad++; $display("FAIL rm_restart: got req=%0h inst=%h want 1 0", imem_bus.req, core_inst); end
    step();
  endtask

  task automatic test_misaligned();
    core_pc = 32'h38; core_den = 1'b1; core_dwe = 1'b1; core_daddr = 32'h41; core_dwdata = 32'h5555;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'hAC02_0041;
    exp_iq.push_back(32'hAC02_0041);
    @(negedge clk);
    n_vec++; if (stall !== 1'b1 || dmem_bus.req !== 1'b0) begin n_bad++; $display("FAIL mis_a: got stall=%0h req=%0h want 1 0", stall, dmem_bus.req); end
    step();
    imem_bus.ack = 1'b0;
    @(negedge clk);
    n_vec++; if (dmem_bus.req !== 1'b0 || err !== 1'b0 || stall !== 1'b1) begin
      n_bad++; $display("FAIL mis_b: got req=%0h err=%0h stall=%0h want 0 0 1", dmem_bus.req, err, stall);
    end
    step();
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %0h want 1", err); end
    n_vec++; if (stall !== 1'b0 || dmem_bus.req !== 1'b0) begin n_bad++; $display("FAIL mis_adv: got stall=%0h req=%0h want 0 0", stall, dmem_bus.req); end
    exp = exp_iq.pop_front();
    n_vec++; if (core_inst !== exp) begin n_bad++; $display("FAIL mis_inst: got %h want %h", core_inst, exp); end
    step();
    core_den = 1'b0; core_dwe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_i_latency();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid();
    test_misaligned();
    n_vec++; if (exp_iq.size() != 0 || exp_dq.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d/%0d left want 0/0", exp_iq.size(), exp_dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
